// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode enum, instruction field positions and the
// encoder FSM state enum, used by both the program encoder and the decoder.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_BRNZP = 4'd1,
        OP_CMP   = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MUL   = 4'd5,
        OP_DIV   = 4'd6,
        OP_LDR   = 4'd7,
        OP_STR   = 4'd8,
        OP_CONST = 4'd9,
        OP_RET   = 4'd15
    } instruction_t;

    localparam int OPCODE_LSB = 12;
    localparam int RD_LSB     = 8;
    localparam int RS_LSB     = 4;
    localparam int RT_LSB     = 0;
    localparam int NZP_LSB    = 9;
    localparam int IMM_LSB    = 0;
    localparam int FIELD_W    = 4;
    localparam int NZP_W      = 3;
    localparam int IMM_W      = 8;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_ACCEPT,
        ENC_WRITE,
        ENC_DONE
    } enc_state_t;

    // Opcodes 10..14 have no defined instruction.
    function automatic logic is_reserved_opcode(input logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer: structured fields in, 16-bit word out.
// Fields not used by an opcode are forced to zero.
module instr_pack
    import isa_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [2:0]  nzp,
    input  logic [7:0]  immediate,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        word[OPCODE_LSB +: FIELD_W] = opcode;
        case (opcode)
            OP_NOP, OP_RET: begin
            end
            OP_BRNZP: begin
                word[NZP_LSB +: NZP_W] = nzp;
                word[IMM_LSB +: IMM_W] = immediate;
            end
            OP_CMP, OP_STR: begin
                word[RS_LSB +: FIELD_W] = rs;
                word[RT_LSB +: FIELD_W] = rt;
            end
            OP_LDR: begin
                word[RD_LSB +: FIELD_W] = rd;
                word[RS_LSB +: FIELD_W] = rs;
            end
            OP_CONST: begin
                word[RD_LSB +: FIELD_W] = rd;
                word[IMM_LSB +: IMM_W]  = immediate;
            end
            // ALU ops and reserved opcodes share the three-register layout
            default: begin
                word[RD_LSB +: FIELD_W] = rd;
                word[RS_LSB +: FIELD_W] = rs;
                word[RT_LSB +: FIELD_W] = rt;
            end
        endcase
    end

endmodule

// File: rtl/program_encoder.sv
// Packs instruction requests and streams them into program memory at
// consecutive addresses. Define PROGRAM_ENCODER_OPCODE_CHECK_EN to drop reserved opcodes.
module program_encoder
    import isa_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [3:0]                       req_opcode,
    input  logic [3:0]                       req_rd,
    input  logic [3:0]                       req_rs,
    input  logic [3:0]                       req_rt,
    input  logic [2:0]                       req_nzp,
    input  logic [7:0]                       req_immediate,
    input  logic                             req_last,
    output logic                             mem_write_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_write_address,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] mem_write_data,
    input  logic                             mem_write_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             error,
    output logic [PROGRAM_MEM_ADDR_BITS:0]   instr_count
);

    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;

    enc_state_t     state_reg, state_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [DW-1:0]  data_reg, data_next;
    logic           last_reg, last_next;
    logic [AW:0]    count_reg, count_next;
    logic           overflow_reg, overflow_next;
    logic           error_reg, error_next;
    logic [15:0]    packed_word;
    logic           illegal_op;

    instr_pack u_pack (
        .opcode    (req_opcode),
        .rd        (req_rd),
        .rs        (req_rs),
        .rt        (req_rt),
        .nzp       (req_nzp),
        .immediate (req_immediate),
        .word      (packed_word)
    );

`ifdef PROGRAM_ENCODER_OPCODE_CHECK_EN
    assign illegal_op = is_reserved_opcode(req_opcode);
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ENC_IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            last_reg     <= 1'b0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            last_reg     <= last_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        last_next     = last_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        error_next    = error_reg;
        case (state_reg)
            ENC_IDLE: begin
                if (start) begin
                    addr_next     = base_addr;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    error_next    = 1'b0;
                    state_next    = ENC_ACCEPT;
                end
            end
            ENC_ACCEPT: begin
                if (req_valid) begin
                    if (illegal_op) begin
                        // Consumed but never written; address and count untouched.
                        error_next = 1'b1;
                        state_next = req_last ? ENC_DONE : ENC_ACCEPT;
                    end else begin
                        data_next  = DW'(packed_word);
                        last_next  = req_last;
                        state_next = ENC_WRITE;
                    end
                end
            end
            ENC_WRITE: begin
                if (mem_write_ready) begin
                    count_next = count_reg + (AW+1)'(1);
                    addr_next  = addr_reg + AW'(1);
                    if (last_reg) begin
                        state_next = ENC_DONE;
                    end else if (&addr_reg) begin
                        // Top of memory reached without req_last: stop before wrapping.
                        overflow_next = 1'b1;
                        state_next    = ENC_DONE;
                    end else begin
                        state_next = ENC_ACCEPT;
                    end
                end
            end
            ENC_DONE: begin
                state_next = ENC_IDLE;
            end
            default: begin
                state_next = ENC_IDLE;
            end
        endcase
    end

    assign req_ready         = (state_reg == ENC_ACCEPT);
    assign mem_write_valid   = (state_reg == ENC_WRITE);
    assign mem_write_address = addr_reg;
    assign mem_write_data    = data_reg;
    assign busy              = (state_reg != ENC_IDLE);
    assign done              = (state_reg == ENC_DONE);
    assign overflow          = overflow_reg;
    assign error             = error_reg;
    assign instr_count       = count_reg;

endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder: scoreboard of expected memory writes
// built from an independent packing model, plus literal word/address checks.
module tb_program_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode, req_rd, req_rs, req_rt;
    logic [2:0]  req_nzp;
    logic [7:0]  req_immediate;
    logic        req_last;
    logic        mem_write_valid;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic        mem_write_ready;
    logic        busy, done, overflow, error;
    logic [8:0]  instr_count;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;

    logic [23:0] exp_q[$];
    logic [15:0] log_data[$];
    logic [7:0]  log_addr[$];
    logic [7:0]  model_addr;

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;

    always #5 clk = ~clk;

    program_encoder dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_opcode        (req_opcode),
        .req_rd            (req_rd),
        .req_rs            (req_rs),
        .req_rt            (req_rt),
        .req_nzp           (req_nzp),
        .req_immediate     (req_immediate),
        .req_last          (req_last),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow),
        .error             (error),
        .instr_count       (instr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction layout written straight from the ISA table.
    function automatic logic [15:0] model_pack(input logic [3:0] op, input logic [3:0] rd,
            input logic [3:0] rs, input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm);
        case (op)
            4'd0, 4'd15: return {op, 12'h000};
            4'd1:        return {op, nzp, 1'b0, imm};
            4'd2, 4'd8:  return {op, 4'h0, rs, rt};
            4'd7:        return {op, rd, rs, 4'h0};
            4'd9:        return {op, rd, imm};
            default:     return {op, rd, rs, rt};
        endcase
    endfunction

    // Compare process: every cycle a write is presented, match it to the scoreboard.
    always @(negedge clk) begin
        if (done) done_count++;
        if (mem_write_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {8'h0, mem_write_address, mem_write_data}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", mem_write_address, exp_q[0][23:16]);
                check("wr_data", mem_write_data, exp_q[0][15:0]);
                check("ready_during_write", req_ready, 1'b0);
                if (prev_stall) begin
                    check("stall_addr_stable", mem_write_address, prev_addr);
                    check("stall_data_stable", mem_write_data, prev_data);
                end
                if (mem_write_ready) begin
                    void'(exp_q.pop_front());
                    log_addr.push_back(mem_write_address);
                    log_data.push_back(mem_write_data);
                end
            end
        end
        prev_stall = mem_write_valid && !mem_write_ready;
        prev_addr  = mem_write_address;
        prev_data  = mem_write_data;
    end

    task automatic do_start(input logic [7:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        model_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'h00;
    endtask

    task automatic send_req(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
            input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm, input logic last,
            input bit expect_accept, input bit push);
        bit accepted = 1'b0;
        req_valid = 1'b1;
        req_opcode = op; req_rd = rd; req_rs = rs; req_rt = rt;
        req_nzp = nzp; req_immediate = imm; req_last = last;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                if (push) begin
                    exp_q.push_back({model_addr, model_pack(op, rd, rs, rt, nzp, imm)});
                    model_addr = model_addr + 8'd1;
                end
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_last = 1'b0;
        check("req_accepted", accepted, expect_accept);
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                check("busy_in_done", busy, 1'b1);
                break;
            end
        end
        check("done_seen", found, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b0);
        check({tag, "_wr_valid"}, mem_write_valid, 1'b0);
        check({tag, "_wr_addr"}, mem_write_address, 8'h00);
        check({tag, "_wr_data"}, mem_write_data, 16'h0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_count"}, instr_count, 9'd0);
    endtask

    logic [3:0]  t_op[11]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    logic [3:0]  t_rd[11]  = '{4'hF, 4'hF, 4'h5, 4'h3, 4'h4, 4'h7, 4'hA, 4'h1, 4'h1, 4'h7, 4'hF};
    logic [3:0]  t_rs[11]  = '{4'hF, 4'hF, 4'h1, 4'h1, 4'h5, 4'h8, 4'hB, 4'h2, 4'h2, 4'hF, 4'hF};
    logic [3:0]  t_rt[11]  = '{4'hF, 4'hF, 4'h2, 4'h2, 4'h6, 4'h9, 4'hC, 4'h3, 4'h3, 4'hF, 4'hF};
    logic [2:0]  t_nzp[11] = '{3'h7, 3'h5, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7};
    logic [7:0]  t_imm[11] = '{8'hFF, 8'h2A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF};
    logic [15:0] t_exp[11] = '{16'h0000, 16'h1A2A, 16'h2012, 16'h3312, 16'h4456, 16'h5789,
                               16'h6ABC, 16'h7120, 16'h8023, 16'h9780, 16'hF000};

    initial begin
        int base;
        int d0;
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; req_valid = 1'b0;
        req_opcode = 4'h0; req_rd = 4'h0; req_rs = 4'h0; req_rt = 4'h0;
        req_nzp = 3'h0; req_immediate = 8'h00; req_last = 1'b0; mem_write_ready = 1'b1;
        model_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic ADD
        do_start(8'h10);
        base = log_data.size();
        send_req(4'd3, 4'd3, 4'd1, 4'd2, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("add_nwrites", log_data.size() - base, 1);
        check("add_addr", log_addr[base], 8'h10);
        check("add_data", log_data[base], 16'h3312);
        check("add_count", instr_count, 9'd1);
        check("add_overflow", overflow, 1'b0);
        $display("session basic_add done, count=%0d", instr_count);

        // Full ISA stream with unused-field masking
        do_start(8'h20);
        base = log_data.size();
        for (int i = 0; i < 11; i++)
            send_req(t_op[i], t_rd[i], t_rs[i], t_rt[i], t_nzp[i], t_imm[i], (i == 10), 1'b1, 1'b1);
        wait_done();
        check("isa_nwrites", log_data.size() - base, 11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("isa_addr_%0d", i), log_addr[base+i], 8'h20 + 8'(i));
            check($sformatf("isa_data_op%0d", t_op[i]), log_data[base+i], t_exp[i]);
        end
        check("isa_count", instr_count, 9'd11);
        $display("session full_isa done, count=%0d", instr_count);

        // Backpressure: memory stalls for 5 cycles
        do_start(8'h40);
        base = log_data.size();
        mem_write_ready = 1'b0;
        send_req(4'd6, 4'd9, 4'd8, 4'd7, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", mem_write_valid, 1'b1);
            check("bp_addr", mem_write_address, 8'h40);
            check("bp_data", mem_write_data, 16'h6987);
            check("bp_req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1;
        mem_write_ready = 1'b1;
        wait_done();
        check("bp_nwrites", log_data.size() - base, 1);
        $display("session backpressure done, count=%0d", instr_count);

        // Overflow at top of address space
        do_start(8'hFE);
        base = log_data.size();
        d0 = done_count;
        send_req(4'd3, 4'd1, 4'd2, 4'd3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        send_req(4'd4, 4'd4, 4'd5, 4'd6, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        send_req(4'd5, 4'd7, 4'd8, 4'd9, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("ovf_nwrites", log_data.size() - base, 2);
        check("ovf_addr0", log_addr[base], 8'hFE);
        check("ovf_data0", log_data[base], 16'h3123);
        check("ovf_addr1", log_addr[base+1], 8'hFF);
        check("ovf_data1", log_data[base+1], 16'h4456);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_done_pulses", done_count - d0, 1);
        check("ovf_count", instr_count, 9'd2);
        check("ovf_busy", busy, 1'b0);
        $display("session overflow done, count=%0d overflow=%0d", instr_count, overflow);

        // Reset while a write is pending
        do_start(8'h50);
        check("new_start_clears_ovf", overflow, 1'b0);
        mem_write_ready = 1'b0;
        send_req(4'd3, 4'd1, 4'd1, 4'd1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("rst_pre_valid", mem_write_valid, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        mem_write_ready = 1'b1;
        do_start(8'h60);
        base = log_data.size();
        send_req(4'd9, 4'd2, 4'd0, 4'd0, 3'd0, 8'h5A, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("postrst_addr", log_addr[base], 8'h60);
        check("postrst_data", log_data[base], 16'h925A);
        check("postrst_count", instr_count, 9'd1);
        $display("session reset_recovery done, count=%0d", instr_count);

        // Reserved opcode 12
        do_start(8'h70);
        base = log_data.size();
`ifdef PROGRAM_ENCODER_OPCODE_CHECK_EN
        send_req(4'd12, 4'd1, 4'd2, 4'd3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("op12_error", error, 1'b1);
        check("op12_count", instr_count, 9'd0);
        check("op12_no_write", mem_write_valid, 1'b0);
        send_req(4'd3, 4'd3, 4'd1, 4'd2, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("op12_nwrites", log_data.size() - base, 1);
        check("op12_next_addr", log_addr[base], 8'h70);
        check("op12_next_data", log_data[base], 16'h3312);
        check("op12_final_count", instr_count, 9'd1);
        check("op12_error_sticky", error, 1'b1);
`else
        send_req(4'd12, 4'd1, 4'd2, 4'd3, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("op12_nwrites", log_data.size() - base, 1);
        check("op12_addr", log_addr[base], 8'h70);
        check("op12_data", log_data[base], 16'hC123);
        check("op12_error", error, 1'b0);
`endif
        $display("session opcode12 done, count=%0d error=%0d", instr_count, error);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
